// File: rtl/adc_sample_controller_pkg.sv
// Shared types and frame geometry for the serial ADC sample controller.
// Build option: ADC_CTRL_AVG_EN enables 4-sample averaging in adc_sample_controller.
package adc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        QUIET = 2'd2
    } state_e;

    localparam int FRAME_BITS = 16;
    localparam int DATA_BITS  = 12;
    localparam int AVG_DEPTH  = 4;

    // 2*FRAME_BITS SCLK toggles per frame; the last one is the final rise.
    localparam int EDGE_BITS  = 5;
    localparam int LAST_EDGE  = 2 * FRAME_BITS - 1;

    localparam int AVG_CNT_BITS = $clog2(AVG_DEPTH);
    localparam int ACC_BITS     = DATA_BITS + AVG_CNT_BITS;

    // Mean of AVG_DEPTH samples: drop the low bits of the running sum.
    function automatic logic [DATA_BITS-1:0] avg_of(input logic [ACC_BITS-1:0] sum);
        return sum[ACC_BITS-1 -: DATA_BITS];
    endfunction

endpackage

// File: rtl/adc_sample_controller_if.sv
// Control, ADC pin and sample-consumer signals of the ADC sample controller.
// master = controller side, slave = ADC/consumer side.
interface adc_sample_controller_if;
    import adc_ctrl_pkg::*;

    logic                 enable;
    logic                 start;
    logic                 sdata;
    logic                 sclk;
    logic                 cs;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 busy;
    logic                 overrun;

    modport master (
        input  enable, start, sdata,
        output sclk, cs, data_out, data_valid, busy, overrun
    );

    modport slave (
        output enable, start, sdata,
        input  sclk, cs, data_out, data_valid, busy, overrun
    );

endinterface

// File: rtl/adc_sample_controller_sclk_gen.sv
// SCLK divider for the ADC frame: toggles every CLK_DIV clk while run is high,
// idles high, and flags the clk edge on which the next fall or rise happens.
module adc_sclk_gen
    import adc_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    output logic                 sclk,
    output logic                 fall_stb,
    output logic                 rise_stb,
    output logic [EDGE_BITS-1:0] edge_cnt
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0]     div_reg;
    logic                 sclk_reg;
    logic [EDGE_BITS-1:0] edge_reg;
    logic                 div_end;

    assign div_end  = (div_reg == DIV_W'(CLK_DIV - 1));

    // Strobes are combinational so the caller acts on the same edge that moves sclk.
    assign fall_stb = run && div_end && sclk_reg;
    assign rise_stb = run && div_end && !sclk_reg;

    always_ff @(posedge clk) begin
        if (!reset || !run) begin
            div_reg  <= '0;
            sclk_reg <= 1'b1;
            edge_reg <= '0;
        end else if (div_end) begin
            div_reg  <= '0;
            sclk_reg <= !sclk_reg;
            edge_reg <= edge_reg + 1'b1;
        end else begin
            div_reg  <= div_reg + 1'b1;
        end
    end

    assign sclk     = sclk_reg;
    assign edge_cnt = edge_reg;

endmodule

// File: rtl/adc_sample_controller.sv
// Master sequencer for a 16-bit serial ADC frame: schedules conversions, drives CS/SCLK,
// shifts in SDATA and presents 12-bit samples. Build option: ADC_CTRL_AVG_EN (4-sample average).
module adc_sample_controller
    import adc_ctrl_pkg::*;
#(
    parameter int CLK_DIV       = 3,
    parameter int QUIET_CYCLES  = 5,
    parameter int SAMPLE_PERIOD = 2000
) (
    input  logic                    clk,
    input  logic                    reset,
    adc_sample_controller_if.master bus
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_FRAME = FRAME;
    localparam logic [1:0] S_QUIET = QUIET;

    localparam int QW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
    localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

    logic [1:0]           state_reg;
    logic                 cs_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] data_out_reg;
    logic                 valid_reg;
    logic [QW-1:0]        quiet_reg;
    logic [PW-1:0]        period_reg;

    logic                 run;
    logic                 sclk_w;
    logic                 sclk_fall;
    logic                 sclk_rise;
    logic [EDGE_BITS-1:0] edge_cnt;
    logic                 period_tick;
    logic                 trigger;
    logic                 frame_done;

    adc_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .sclk     (sclk_w),
        .fall_stb (sclk_fall),
        .rise_stb (sclk_rise),
        .edge_cnt (edge_cnt)
    );

    assign run         = (state_reg == S_FRAME);
    assign period_tick = bus.enable && (period_reg == PW'(SAMPLE_PERIOD - 1));
    assign trigger     = bus.start || period_tick;
    assign frame_done  = run && sclk_rise && (edge_cnt == EDGE_BITS'(LAST_EDGE));

    always_ff @(posedge clk) begin
        if (!reset || !bus.enable) begin
            period_reg <= '0;
        end else if (period_tick) begin
            period_reg <= '0;
        end else begin
            period_reg <= period_reg + 1'b1;
        end
    end

    // Only DATA_BITS of history are kept: the four leading frame bits simply
    // fall off the top after sixteen shifts, which is all the frame needs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            cs_reg    <= 1'b1;
            quiet_reg <= '0;
            shift_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (trigger) begin
                        state_reg <= S_FRAME;
                        cs_reg    <= 1'b0;
                    end
                end
                S_FRAME: begin
                    if (sclk_fall) begin
                        shift_reg <= {shift_reg[DATA_BITS-2:0], bus.sdata};
                    end
                    if (frame_done) begin
                        state_reg <= S_QUIET;
                        cs_reg    <= 1'b1;
                        quiet_reg <= '0;
                    end
                end
                S_QUIET: begin
                    if (quiet_reg == QW'(QUIET_CYCLES - 1)) begin
                        state_reg <= S_IDLE;
                    end else begin
                        quiet_reg <= quiet_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    cs_reg    <= 1'b1;
                end
            endcase
        end
    end

`ifdef ADC_CTRL_AVG_EN
    logic [ACC_BITS-1:0]     acc_reg;
    logic [ACC_BITS-1:0]     acc_sum;
    logic [AVG_CNT_BITS-1:0] avg_cnt_reg;
    logic                    enable_d_reg;

    assign acc_sum = acc_reg + ACC_BITS'(shift_reg);

    // A falling enable discards a partial average so the next group starts clean.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_out_reg <= '0;
            valid_reg    <= 1'b0;
            acc_reg      <= '0;
            avg_cnt_reg  <= '0;
            enable_d_reg <= 1'b0;
        end else begin
            valid_reg    <= 1'b0;
            enable_d_reg <= bus.enable;
            if (enable_d_reg && !bus.enable) begin
                acc_reg     <= '0;
                avg_cnt_reg <= '0;
            end else if (frame_done) begin
                if (avg_cnt_reg == AVG_CNT_BITS'(AVG_DEPTH - 1)) begin
                    data_out_reg <= avg_of(acc_sum);
                    valid_reg    <= 1'b1;
                    acc_reg      <= '0;
                    avg_cnt_reg  <= '0;
                end else begin
                    acc_reg      <= acc_sum;
                    avg_cnt_reg  <= avg_cnt_reg + 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_out_reg <= '0;
            valid_reg    <= 1'b0;
        end else begin
            valid_reg <= frame_done;
            if (frame_done) begin
                data_out_reg <= shift_reg;
            end
        end
    end
`endif

    assign bus.sclk       = sclk_w;
    assign bus.cs         = cs_reg;
    assign bus.data_out   = data_out_reg;
    assign bus.data_valid = valid_reg;
    assign bus.busy       = (state_reg != S_IDLE);
    assign bus.overrun    = period_tick && (state_reg != S_IDLE);

endmodule
